// File: rtl/v_ber_accum.sv
// ---------------------------------------------------------------------------
// v_ber_accum
//
// Accumulates bit-error statistics from the per-bit error-flag vector that
// the BER checker produces. Over a window of win_len valid words it counts
// the total errored bits, the number of words with at least one errored bit,
// and the worst single-word error count. Results are held with a done level
// until the next start or reset.
//
// Datapath: stage 1 registers popcount(flag) (p_cnt/p_vld), stage 2 folds
// the registered count into the saturating accumulators.
//
// Ports:
//   clk        in   sampling clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle pulse, arms (or restarts) a measurement
//   win_len    in   window length in valid words, latched on start
//   flag       in   per-bit error flags (1 = bit error)
//   flag_valid in   flag word is a counted sample this cycle
//   busy       out  measurement in progress (ARM/RUN/FLUSH)
//   done       out  results valid, held until next start or reset
//   err_bits   out  accumulated errored bits, saturating
//   err_words  out  words with popcount > 0, saturating
//   words      out  valid words accepted in the current window
//   max_err    out  largest single-word popcount in the window
//   sat        out  sticky: err_bits or err_words clamped this window
// ---------------------------------------------------------------------------
module v_ber_accum #(
  parameter int WIDTH = 132,
  parameter int CNT_W = 32,
  parameter int WIN_W = 24,
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIDTH-1:0] flag,
  input  logic             flag_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_bits,
  output logic [CNT_W-1:0] err_words,
  output logic [WIN_W-1:0] words,
  output logic [PC_W-1:0]  max_err,
  output logic             sat
);

  // Popcount tree geometry: nibble leaves, padded up to a power of two.
  localparam int NG  = (WIDTH + 3) / 4;
  localparam int LVL = (NG > 1) ? $clog2(NG) : 0;
  localparam int NP  = 1 << LVL;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Number of set bits in a nibble.
  function automatic logic [2:0] nib_cnt(input logic [3:0] n);
    nib_cnt = {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // Balanced adder tree over nibble counts, stored heap-style:
  // node i has children 2i+1 and 2i+2, leaves occupy NP-1 .. 2NP-2.
  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [4*NG-1:0] pv;
    logic [PC_W-1:0] node [2*NP-1];
    pv = '0;
    pv[WIDTH-1:0] = v;
    for (int i = 0; i < NG; i++) begin
      node[NP-1+i] = PC_W'(nib_cnt(pv[4*i +: 4]));
    end
    for (int i = NG; i < NP; i++) begin
      node[NP-1+i] = '0;
    end
    for (int i = NP - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    popcount = node[0];
  endfunction

  state_t           state_r;
  state_t           state_nxt;
  logic [WIN_W-1:0] win_len_r;
  logic [PC_W-1:0]  p_cnt_r;
  logic             p_vld_r;

  logic             accept_s;
  logic             last_s;
  logic [WIN_W-1:0] words_inc_s;
  logic [PC_W-1:0]  pc_s;
  logic [CNT_W:0]   bits_sum_s;
  logic [CNT_W:0]   wrds_sum_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  // Word acceptance: only in RUN, and a start in the same cycle drops the word.
  always_comb begin
    accept_s    = 1'b0;
    last_s      = 1'b0;
    words_inc_s = words + WIN_W'(1);
    pc_s        = popcount(flag);
    if ((state_r == S_RUN) && flag_valid && !start) begin
      accept_s = 1'b1;
      last_s   = (words_inc_s == win_len_r);
    end else begin
      accept_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  // Next-state and registered-output decode; start restarts from any state.
  always_comb begin
    state_nxt = state_r;
    if (start) begin
      state_nxt = S_ARM;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt = S_IDLE;
        S_ARM: begin
          if (win_len_r == '0) begin
            state_nxt = S_FLUSH;
          end else begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (last_s) begin
            state_nxt = S_FLUSH;
          end else begin
            state_nxt = S_RUN;
          end
        end
        S_FLUSH: state_nxt = S_DONE;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
    busy_nxt_s = (state_nxt == S_ARM) || (state_nxt == S_RUN) ||
                 (state_nxt == S_FLUSH);
    done_nxt_s = (state_nxt == S_DONE);
  end

  // One extra bit on each sum exposes the overflow used for clamping.
  always_comb begin
    bits_sum_s = {1'b0, err_bits}  + (CNT_W+1)'(p_cnt_r);
    wrds_sum_s = {1'b0, err_words} + (CNT_W+1)'(p_cnt_r != '0);
  end

  // Control state, status outputs and latched window length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_len_r <= '0;
    end else begin
      state_r <= state_nxt;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
      if (start) begin
        win_len_r <= win_len;
      end
    end
  end

  // Stage 1: register the word popcount and count accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt_r <= '0;
      p_vld_r <= 1'b0;
      words   <= '0;
    end else if (start) begin
      p_cnt_r <= '0;
      p_vld_r <= 1'b0;
      words   <= '0;
    end else if (accept_s) begin
      p_cnt_r <= pc_s;
      p_vld_r <= 1'b1;
      words   <= words_inc_s;
    end else begin
      p_vld_r <= 1'b0;
    end
  end

  // Stage 2: saturating accumulation and running maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bits  <= '0;
      err_words <= '0;
      max_err   <= '0;
      sat       <= 1'b0;
    end else if (start) begin
      err_bits  <= '0;
      err_words <= '0;
      max_err   <= '0;
      sat       <= 1'b0;
    end else if (p_vld_r) begin
      err_bits  <= bits_sum_s[CNT_W] ? '1 : bits_sum_s[CNT_W-1:0];
      err_words <= wrds_sum_s[CNT_W] ? '1 : wrds_sum_s[CNT_W-1:0];
      sat       <= sat | bits_sum_s[CNT_W] | wrds_sum_s[CNT_W];
      if (p_cnt_r > max_err) begin
        max_err <= p_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_v_ber_accum.sv
// ---------------------------------------------------------------------------
// tb_v_ber_accum
//
// Self-checking bench for v_ber_accum. Two instances share stimulus: one with
// default widths and one with 8-bit accumulators to reach saturation.
// A table of directed windows, a few hand-written disruption sequences and
// randomized windows checked against a window-level reference model.
// ---------------------------------------------------------------------------
module tb_v_ber_accum;

  localparam int WIDTH = 132;
  localparam int CNT_W = 32;
  localparam int WIN_W = 24;
  localparam int PC_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic [WIDTH-1:0] flag;
  logic             flag_valid;

  logic             busy, done, sat;
  logic [CNT_W-1:0] err_bits, err_words;
  logic [WIN_W-1:0] words;
  logic [PC_W-1:0]  max_err;

  logic             busy8, done8, sat8;
  logic [7:0]       err_bits8, err_words8;
  logic [WIN_W-1:0] words8;
  logic [PC_W-1:0]  max_err8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  v_ber_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .flag(flag), .flag_valid(flag_valid), .busy(busy), .done(done),
    .err_bits(err_bits), .err_words(err_words), .words(words),
    .max_err(max_err), .sat(sat)
  );

  v_ber_accum #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .flag(flag), .flag_valid(flag_valid), .busy(busy8), .done(done8),
    .err_bits(err_bits8), .err_words(err_words8), .words(words8),
    .max_err(max_err8), .sat(sat8)
  );

  typedef struct packed {
    int              wl;
    bit              gated;
    logic [3:0][7:0] pops;
    int              cyc;
    longint          bits;
    longint          werr;
    int              mx;
    longint          bits8;
    bit              sat8;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_vec(input int wl, input bit g, input int p0,
                                  input int p1, input int p2, input int p3,
                                  input int cyc, input longint b, input longint w,
                                  input int mx, input longint b8, input bit s8);
    vec_t v;
    v.wl = wl; v.gated = g;
    v.pops = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    v.cyc = cyc; v.bits = b; v.werr = w; v.mx = mx; v.bits8 = b8; v.sat8 = s8;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] mk_flag(input int n);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_flag();
    logic [159:0] t;
    int m;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    m = $urandom_range(0, 3);
    case (m)
      0:       t = '0;
      1:       t = '1;
      2:       t = t;
      default: t = t & {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}
                     & {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endcase
    return t[WIDTH-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one window from a start pulse to done, modelling which words the
  // window must accept: the first wl valid words after the one-cycle ARM slot.
  task automatic run_window(input int wl, input bit gated, input bit rnd,
                            input logic [3:0][7:0] pops,
                            output int edges, output int acc,
                            output longint m_bits, output longint m_werr,
                            output int m_max, output int exp_edges,
                            output bit timeout);
    logic [WIDTH-1:0] f;
    bit v;
    int c, c_last, pc;
    start = 1'b1;
    win_len = WIN_W'(wl);
    flag_valid = 1'b1;
    flag = '1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    edges = 0; c = 0; acc = 0; c_last = 0;
    m_bits = 0; m_werr = 0; m_max = 0;
    while (done !== 1'b1 && edges < 300) begin
      if (rnd) begin
        v = ($urandom_range(0, 9) < 7);
        f = rnd_flag();
      end else if (c == 0 || acc >= wl) begin
        v = 1'b1;
        f = '1;
      end else if (gated && (c % 2 == 1)) begin
        v = 1'b0;
        f = '1;
      end else begin
        v = 1'b1;
        f = mk_flag(int'(pops[acc % 4]));
      end
      if (c >= 1 && v && acc < wl) begin
        pc = $countones(f);
        acc++;
        m_bits += pc;
        if (pc != 0) m_werr++;
        if (pc > m_max) m_max = pc;
        c_last = c;
      end
      flag = f;
      flag_valid = v;
      step();
      edges++;
      c++;
    end
    timeout = (done !== 1'b1);
    exp_edges = (wl == 0) ? 2 : c_last + 2;
    flag_valid = 1'b0;
    flag = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, acc, m_max, exp_edges, wl;
    longint m_bits, m_werr, e8;
    bit timeout;
    logic [31:0] held;

    vecs[0] = mk_vec(10, 1'b0,   0,   0,   0,   0, 12,   0, 0,   0,   0, 1'b0);
    vecs[1] = mk_vec( 5, 1'b0,   1,   1,   1,   1,  7,   5, 5,   1,   5, 1'b0);
    vecs[2] = mk_vec( 3, 1'b0, 132, 132, 132, 132,  5, 396, 3, 132, 255, 1'b1);
    vecs[3] = mk_vec( 4, 1'b1,   3,   0,   7,   1, 10,  11, 3,   7,  11, 1'b0);
    vecs[4] = mk_vec( 2, 1'b0, 132, 132, 132, 132,  4, 264, 2, 132, 255, 1'b1);
    vecs[5] = mk_vec( 0, 1'b0,   0,   0,   0,   0,  2,   0, 0,   0,   0, 1'b0);

    rst_n = 1'b0; start = 1'b0; win_len = '0; flag = '0; flag_valid = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_bits", err_bits, 0);
    chk("rst_err_words", err_words, 0);
    chk("rst_words", words, 0);
    chk("rst_max_err", max_err, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Directed windows.
    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i].wl, vecs[i].gated, 1'b0, vecs[i].pops,
                 edges, acc, m_bits, m_werr, m_max, exp_edges, timeout);
      chk($sformatf("v%0d_timeout", i), timeout, 0);
      chk($sformatf("v%0d_latency", i), edges, vecs[i].cyc);
      chk($sformatf("v%0d_err_bits", i), err_bits, vecs[i].bits);
      chk($sformatf("v%0d_err_words", i), err_words, vecs[i].werr);
      chk($sformatf("v%0d_max_err", i), max_err, vecs[i].mx);
      chk($sformatf("v%0d_words", i), words, vecs[i].wl);
      chk($sformatf("v%0d_sat", i), sat, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_model_bits", i), err_bits, m_bits);
      chk($sformatf("v%0d_err_bits8", i), err_bits8, vecs[i].bits8);
      chk($sformatf("v%0d_sat8", i), sat8, vecs[i].sat8);
      chk($sformatf("v%0d_err_words8", i), err_words8, vecs[i].werr);
      chk($sformatf("v%0d_max_err8", i), max_err8, vecs[i].mx);
      // Results must hold in DONE while traffic keeps arriving.
      held = err_bits;
      flag = '1;
      flag_valid = 1'b1;
      repeat (3) step();
      chk($sformatf("v%0d_hold_done", i), done, 1);
      chk($sformatf("v%0d_hold_bits", i), err_bits, held);
      flag_valid = 1'b0;
      flag = '0;
    end

    // Restart mid-RUN: the in-flight word and partial counts are discarded.
    start = 1'b1; win_len = WIN_W'(10); step(); start = 1'b0;
    flag = mk_flag(5); flag_valid = 1'b1;
    repeat (4) step();
    chk("rs_words_before", words, 3);
    run_window(3, 1'b0, 1'b0, {8'd2, 8'd2, 8'd2, 8'd2},
               edges, acc, m_bits, m_werr, m_max, exp_edges, timeout);
    chk("rs_timeout", timeout, 0);
    chk("rs_latency", edges, 5);
    chk("rs_err_bits", err_bits, 6);
    chk("rs_err_words", err_words, 3);
    chk("rs_max_err", max_err, 2);
    chk("rs_words", words, 3);

    // Reset mid-RUN: outputs clear asynchronously and the FSM idles.
    start = 1'b1; win_len = WIN_W'(20); step(); start = 1'b0;
    flag = mk_flag(9); flag_valid = 1'b1;
    repeat (6) step();
    chk("mr_busy", busy, 1);
    chk("mr_words", words, 5);
    chk("mr_err_bits", err_bits, 36);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err_bits", err_bits, 0);
    chk("ar_err_words", err_words, 0);
    chk("ar_words", words, 0);
    chk("ar_max_err", max_err, 0);
    chk("ar_sat", sat, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_done", done, 0);
    chk("ar_idle_words", words, 0);
    chk("ar_idle_bits", err_bits, 0);
    flag_valid = 1'b0;
    flag = '0;

    // Randomized windows against the reference model.
    for (int r = 0; r < 40; r++) begin
      wl = $urandom_range(0, 12);
      run_window(wl, 1'b0, 1'b1, '0,
                 edges, acc, m_bits, m_werr, m_max, exp_edges, timeout);
      e8 = (m_bits > 255) ? 255 : m_bits;
      chk($sformatf("r%0d_timeout", r), timeout, 0);
      chk($sformatf("r%0d_latency", r), edges, exp_edges);
      chk($sformatf("r%0d_err_bits", r), err_bits, m_bits);
      chk($sformatf("r%0d_err_words", r), err_words, m_werr);
      chk($sformatf("r%0d_max_err", r), max_err, m_max);
      chk($sformatf("r%0d_words", r), words, acc);
      chk($sformatf("r%0d_sat", r), sat, 0);
      chk($sformatf("r%0d_err_bits8", r), err_bits8, e8);
      chk($sformatf("r%0d_sat8", r), sat8, (m_bits > 255) ? 1 : 0);
      chk($sformatf("r%0d_err_words8", r), err_words8, m_werr);
      chk($sformatf("r%0d_max_err8", r), max_err8, m_max);
      chk($sformatf("r%0d_words8", r), words8, acc);
      chk($sformatf("r%0d_done8", r), done8, 1);
      chk($sformatf("r%0d_busy8", r), busy8, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
